// File: rtl/sampler_pkg.sv
// Shared constants for the periodic sampler: capture mode encodings.
package sampler_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_CHANGE   = 1'b1;

endpackage

// File: rtl/tick_div.sv
// Free-running clock-enable divider; emits a one-cycle tick every DIV cycles.
module tick_div #(
    parameter int DIV = 16
) (
    input  logic ext_clk_25m,
    input  logic ext_rst_n,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] PRE_LAST = W'(DIV - 2);

    logic [W-1:0] div_cnt;

    // DIV is a power of two, so the counter wraps naturally; tick is
    // registered one count early so it is high while div_cnt == DIV-1.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= (div_cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/periodic_sampler.sv
// Periodic / change-only bus sampler feeding the LEDs and a valid/ready UART
// path, with capture interrupt pulse, overrun flag and a clock-enable tick.
module periodic_sampler
    import sampler_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                PERIOD_W   = 11,
    parameter int                PERIOD_RST = 2,
    parameter int                TICK_DIV   = 16,
    parameter int                PULSE_LEN  = 6,
    parameter logic [DATA_W-1:0] RESET_VAL  = 'h01,
    parameter int                INVERT_OUT = 1
) (
    input  logic                ext_clk_25m,
    input  logic                ext_rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [PERIOD_W-1:0] period,
    input  logic                mode,
    input  logic                tx_ready,
    input  logic                overrun_clr,
    output logic [DATA_W-1:0]   led,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    output logic                rx_int,
    output logic                overrun,
    output logic                tick
);

    localparam int PW = $clog2(PULSE_LEN + 1);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_sh;
    logic [DATA_W-1:0]   held;
    logic [PW-1:0]       pulse_cnt;
    logic                ev;
    logic                cap;
    logic                accept;
    logic                drop;

    assign ev     = (cnt == per_sh);
    assign cap    = ev && ((mode == MODE_PERIODIC) || (data_in != held));
    // A capture may land on the same cycle the pending word is taken.
    assign accept = cap && (!tx_valid || tx_ready);
    assign drop   = cap && tx_valid && !tx_ready;

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            cnt       <= '0;
            per_sh    <= PERIOD_W'(PERIOD_RST);
            held      <= RESET_VAL;
            tx_valid  <= 1'b0;
            pulse_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (ev) begin
                cnt    <= '0;
                per_sh <= period;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                held      <= data_in;
                tx_valid  <= 1'b1;
                pulse_cnt <= PW'(PULSE_LEN);
            end else begin
                if (tx_valid && tx_ready)
                    tx_valid <= 1'b0;
                if (pulse_cnt != '0)
                    pulse_cnt <= pulse_cnt - 1'b1;
            end

            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign led     = (INVERT_OUT != 0) ? ~held : held;
    assign tx_data = held;
    assign rx_int  = (pulse_cnt != '0);

    tick_div #(.DIV(TICK_DIV)) u_tick_div (
        .ext_clk_25m (ext_clk_25m),
        .ext_rst_n   (ext_rst_n),
        .tick        (tick)
    );

endmodule

// File: tb/tb_periodic_sampler.sv
// Directed bench for periodic_sampler; e counts rising edges since reset release.
module tb_periodic_sampler;

    logic        ext_clk_25m = 1'b0;
    logic        ext_rst_n;
    logic [7:0]  data_in;
    logic [10:0] period;
    logic        mode;
    logic        tx_ready;
    logic        overrun_clr;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        rx_int;
    logic        overrun;
    logic        tick;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;
    logic [7:0] exp_d;

    periodic_sampler dut (
        .ext_clk_25m (ext_clk_25m),
        .ext_rst_n   (ext_rst_n),
        .data_in     (data_in),
        .period      (period),
        .mode        (mode),
        .tx_ready    (tx_ready),
        .overrun_clr (overrun_clr),
        .led         (led),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .rx_int      (rx_int),
        .overrun     (overrun),
        .tick        (tick)
    );

    always #5 ext_clk_25m = ~ext_clk_25m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Advance to just after rising edge number 'target'.
    task automatic go_to(input int target);
        while (e < target) begin
            @(posedge ext_clk_25m);
            e++;
        end
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_led"},      led,      32'hFE);
        check({tag, "_tx_data"},  tx_data,  32'h01);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_rx_int"},   rx_int,   0);
        check({tag, "_overrun"},  overrun,  0);
        check({tag, "_tick"},     tick,     0);
    endtask

    initial begin
        ext_rst_n   = 1'b0;
        data_in     = 8'hA5;
        period      = 11'd2;
        mode        = 1'b0;
        tx_ready    = 1'b1;
        overrun_clr = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge ext_clk_25m);
        ext_rst_n = 1'b1;

        // First event sampled at edge 3 (cnt 0,1,2).
        go_to(2);
        check("pre_cap_valid", tx_valid, 0);
        check("pre_cap_led",   led,      32'hFE);
        go_to(3);
        check("cap1_led",     led,      32'h5A);
        check("cap1_tx_data", tx_data,  32'hA5);
        check("cap1_valid",   tx_valid, 1);
        check("cap1_rx_int",  rx_int,   1);
        mode = 1'b1;
        go_to(4);
        check("cap1_xfer", tx_valid, 0);
        go_to(8);
        check("pulse_last", rx_int, 1);
        go_to(9);
        check("pulse_end", rx_int, 0);
        go_to(14);
        check("tick_pre", tick, 0);
        go_to(15);
        check("tick_first", tick, 1);
        go_to(16);
        check("tick_after", tick, 0);
        check("chg_same_valid", tx_valid, 0);
        check("chg_same_rx", rx_int, 0);

        // Change-only: 3C captured once, held value repeats do nothing.
        data_in = 8'h3C;
        go_to(18);
        check("chg_3c_data",  tx_data,  32'h3C);
        check("chg_3c_valid", tx_valid, 1);
        go_to(24);
        check("chg_hold_valid", tx_valid, 0);
        check("chg_hold_rx",    rx_int,   0);
        data_in = 8'h3D;
        go_to(26);
        check("chg_3d_early", tx_data, 32'h3C);
        go_to(27);
        check("chg_3d_data",  tx_data,  32'h3D);
        check("chg_3d_valid", tx_valid, 1);
        go_to(30);
        check("chg_3d_once_valid", tx_valid, 0);
        go_to(33);
        check("chg_3d_once_rx", rx_int, 0);

        // Overrun: accepted at 36, dropped at 39 and 42.
        mode     = 1'b0;
        tx_ready = 1'b0;
        data_in  = 8'h11;
        go_to(36);
        check("ovr_cap_data", tx_data, 32'h11);
        check("ovr_cap_ovr",  overrun, 0);
        data_in = 8'h22;
        go_to(39);
        check("ovr_set",       overrun,  1);
        check("ovr_data_hold", tx_data,  32'h11);
        check("ovr_valid",     tx_valid, 1);
        overrun_clr = 1'b1;
        go_to(40);
        check("ovr_clr", overrun, 0);
        overrun_clr = 1'b0;
        go_to(41);
        overrun_clr = 1'b1;
        go_to(42);
        check("ovr_set_beats_clr", overrun, 1);
        check("ovr_data_hold2",    tx_data, 32'h11);
        overrun_clr = 1'b0;
        tx_ready    = 1'b1;
        go_to(43);
        check("ovr_drain", tx_valid, 0);

        // Period 2 -> 9 mid-interval: event at 45, then 55, 65.
        period  = 11'd9;
        data_in = 8'h45;
        go_to(44);
        check("per_pre", tx_data, 32'h11);
        go_to(45);
        check("per_ev45", tx_data, 32'h45);
        data_in = 8'h55;
        go_to(54);
        check("per_pre55", tx_data, 32'h45);
        go_to(55);
        check("per_ev55", tx_data, 32'h55);
        data_in = 8'h65;
        go_to(64);
        check("per_pre65", tx_data, 32'h55);
        go_to(65);
        check("per_ev65", tx_data, 32'h65);

        // Period 0 takes effect at the edge-75 event, then every edge captures.
        period = 11'd0;
        go_to(74);
        exp_d   = 8'h70;
        data_in = exp_d;
        for (int k = 75; k <= 80; k++) begin
            go_to(k);
            check("p0_data",  tx_data,  {24'h0, exp_d});
            check("p0_valid", tx_valid, 1);
            check("p0_rx",    rx_int,   1);
            exp_d   = exp_d + 8'h01;
            data_in = exp_d;
        end

        // Asynchronous reset mid-pulse with a pending word and sticky overrun.
        period  = 11'd2;
        data_in = 8'hA5;
        #2;
        ext_rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge ext_clk_25m);
        ext_rst_n = 1'b1;
        e = 0;
        go_to(3);
        check("rerun_tx_data", tx_data, 32'hA5);
        check("rerun_led",     led,     32'h5A);
        go_to(14);
        check("rerun_tick_pre", tick, 0);
        go_to(15);
        check("rerun_tick", tick, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/periodic_sampler.md
# periodic_sampler

Parametrised periodic input sampler and strobe generator for the UART/LED path. It captures a `DATA_W`-bit input bus on a programmable period, or only when the bus changes, and holds the value for the LED outputs. The same value is offered to the UART transmitter through a valid/ready handshake, with overrun detection. It also generates a timed interrupt pulse and a clock-enable tick that replaces the old derived-clock output.

## Interface
- `DATA_W`, 8: sampled bus width.
- `PERIOD_W`, 11: width of the period counter.
- `PERIOD_RST`, 2: period used from reset until the first wrap.
- `TICK_DIV`, 16: tick interval in cycles; power of two, ≥2.
- `PULSE_LEN`, 6: `rx_int` high time in cycles; ≥1.
- `RESET_VAL`, 'h01: held value after reset.
- `INVERT_OUT`, 1: 1 = `led` is the bitwise inverse of the held value.

- `ext_clk_25m`, in, 1: the single clock, 25 MHz.
- `ext_rst_n`, in, 1: asynchronous, active-low reset.
- `data_in`, in, DATA_W: bus to sample; already synchronous to `ext_clk_25m`.
- `period`, in, PERIOD_W: capture interval minus 1.
- `mode`, in, 1: 0 = periodic, 1 = change-only.
- `tx_ready`, in, 1: UART transmitter accepts data.
- `overrun_clr`, in, 1: clears `overrun`.
- `led`, out, DATA_W: held value, inverted if `INVERT_OUT`.
- `tx_data`, out, DATA_W: held value, never inverted.
- `tx_valid`, out, 1: `tx_data` is pending transfer.
- `rx_int`, out, 1: capture pulse.
- `overrun`, out, 1: sticky flag; a capture was dropped.
- `tick`, out, 1: one-cycle enable every `TICK_DIV` cycles.

## Operation
- Period counter `cnt` counts 0..`per_sh`, then wraps to 0.
- Event: `cnt == per_sh` on the current cycle.
- `per_sh` loads from `period` only on the event cycle, so a new period applies from the next interval.
- `period = 0` gives an event every cycle.
- Capture condition: event AND (`mode == 0` OR `data_in != held`).
- Capture accepted when `tx_valid == 0`, or `tx_valid && tx_ready` on the same cycle. On acceptance:
  - `held <= data_in`;
  - `tx_valid <= 1`;
  - pulse counter loads `PULSE_LEN`.
- Capture while `tx_valid && !tx_ready`: dropped, `held` unchanged, `overrun <= 1`.
- Handshake:
  - Transfer occurs on any cycle with `tx_valid && tx_ready`; `tx_valid` clears on the next edge unless an accepted capture occurs that cycle, in which case it stays 1.
  - `tx_data` is stable while `tx_valid && !tx_ready`.
- `rx_int` is high while the pulse counter is non-zero. A capture during an active pulse reloads the counter, so the pulse extends and no low gap appears.
- `overrun`: set has priority over `overrun_clr` on the same cycle.
- `tick`: free-running divider, high when the divider equals `TICK_DIV-1`. It is independent of `period`.
- Reset mid-operation: all state returns to reset values immediately; any pending `tx_valid` is lost.

## Timing
- Reset values:
  - `cnt = 0`, `per_sh = PERIOD_RST`;
  - `held = RESET_VAL`, so `led = ~RESET_VAL` when `INVERT_OUT = 1`, and `tx_data = RESET_VAL`;
  - `tx_valid = 0`, `rx_int = 0`, `overrun = 0`, `tick = 0`.
- First event after reset release: cycle `PERIOD_RST`, counting the first active edge as cycle 0.
- Event cycle N: `held`, `led`, `tx_data` and `tx_valid` update at edge N+1; `rx_int` is high for cycles N+1..N+PULSE_LEN.
- `tick` first asserts `TICK_DIV-1` cycles after reset release, then every `TICK_DIV` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `sampler_pkg`: mode constants `MODE_PERIODIC = 1'b0` and `MODE_CHANGE = 1'b1`.
- Sub-module `tick_div`:
  - parameter `DIV`;
  - ports `ext_clk_25m`, `ext_rst_n`, `tick`.
- Top level holds the period counter, capture/handshake logic, pulse counter and overrun flag.

## Test plan
- Reset with defaults and `data_in = 8'hA5`, `tx_ready = 1`, `mode = 0` → `led = 8'hFE` during reset; first capture at cycle 2; then `led = 8'h5A`, `tx_data = 8'hA5`, `rx_int` high for 6 cycles.
- `mode = 1`, `data_in` held at `8'h3C` after one capture → no further `tx_valid` or `rx_int`; change to `8'h3D` → exactly one capture at the next event.
- `tx_ready = 0`, two events → first captured, second dropped, `overrun = 1`, `tx_data` unchanged; assert `overrun_clr` in the same cycle as a third dropped event → `overrun` stays 1.
- `period` changed from 2 to 9 mid-interval → current interval still ends after 3 cycles, following intervals are 10 cycles.
- `period = 0`, `tx_ready = 1`, incrementing `data_in` → a capture every cycle, `tx_valid` stays 1, `rx_int` continuously high.
- Assert `ext_rst_n` low mid-pulse with `tx_valid = 1` → all outputs return to reset values asynchronously; `tick` phase restarts.
